multicycle_ctrl: RTL

//  Control unit for the multicycle RV32I-subset processor. It sequences the

---
 rtl/multicycle_ctrl_pkg.sv | 39 +++
 rtl/multicycle_ctrl_alu_decoder.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: FSM states,
// opcodes, funct3 values and ALUCtrl codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational decode of (opcode, funct3, instr[30]) into ALUCtrl and an
// illegal flag; illegal encodings report ALU_AND so they stay inert.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       bit30_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_AND;
        illegal_o  = 1'b0;
        case (opcode_i)
            OPC_R, OPC_I: begin
                case (funct3_i)
                    // instr[30] only turns ADD into SUB for register-register ops
                    F3_ADD:  alu_ctrl_o = (opcode_i == OPC_R && bit30_i) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_ctrl_o = ALU_SLL;
                    F3_SLT:  alu_ctrl_o = ALU_SLT;
                    F3_XOR:  alu_ctrl_o = ALU_XOR;
                    F3_SR:   alu_ctrl_o = bit30_i ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_ctrl_o = ALU_OR;
                    F3_AND:  alu_ctrl_o = ALU_AND;
                    default: illegal_o  = 1'b1;
                endcase
            end
            OPC_LW, OPC_SW: begin
                if (funct3_i == F3_WORD) alu_ctrl_o = ALU_ADD;
                else                     illegal_o  = 1'b1;
            end
            OPC_BEQ: begin
                if (funct3_i == F3_BEQ) alu_ctrl_o = ALU_SUB;
                else                    illegal_o  = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: IF/ID/EX/MEM/WB sequencer, instruction register,
// branch flag and registered strobes. Optional MEM wait states: CTRL_MEM_WAIT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
`ifdef CTRL_MEM_WAIT_EN
    input  logic        dReady,
`endif
    output logic        ALUSrc,
    output logic [3:0]  ALUCtrl,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        loadPC,
    output logic        PCSrc,
    output logic        illegal_instr,
    output logic [2:0]  dbg_state_o
);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        br_taken_q;
    logic        alusrc_q, memtoreg_q, memread_q, memwrite_q;
    logic        regwrite_q, loadpc_q, illegal_q;
    logic [3:0]  aluctrl_q;

    logic [3:0]  dec_alu;
    logic        dec_illegal;
    logic        is_r_d, is_i_d, is_lw_d, is_sw_d, is_beq_d;
    logic        in_instr_d;
    logic        mem_stall;

    // The word on instr is only looked at while in IF; later states use IR.
    assign ir_d = (state_q == S_IF) ? instr : ir_q;

    alu_decoder u_alu_decoder (
        .opcode_i   (ir_d[6:0]),
        .funct3_i   (ir_d[14:12]),
        .bit30_i    (ir_d[30]),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_illegal)
    );

    assign is_r_d   = !dec_illegal && (ir_d[6:0] == OPC_R);
    assign is_i_d   = !dec_illegal && (ir_d[6:0] == OPC_I);
    assign is_lw_d  = !dec_illegal && (ir_d[6:0] == OPC_LW);
    assign is_sw_d  = !dec_illegal && (ir_d[6:0] == OPC_SW);
    assign is_beq_d = !dec_illegal && (ir_d[6:0] == OPC_BEQ);

`ifdef CTRL_MEM_WAIT_EN
    assign mem_stall = (state_q == S_MEM) && (memread_q || memwrite_q) && !dReady;
`else
    assign mem_stall = 1'b0;
`endif

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = S_EX;
            S_EX:    state_d = S_MEM;
            S_MEM:   state_d = mem_stall ? S_MEM : S_WB;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    assign in_instr_d = (state_d != S_IF);

    // Strobes are registered from the next state and next IR, so each output
    // changes cleanly on the edge that enters the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IF;
            ir_q       <= '0;
            br_taken_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= ALU_AND;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            loadpc_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            alusrc_q   <= in_instr_d && (is_i_d || is_lw_d || is_sw_d);
            aluctrl_q  <= in_instr_d ? dec_alu : ALU_AND;
            memtoreg_q <= in_instr_d && is_lw_d;
            memread_q  <= (state_d == S_MEM) && is_lw_d;
            memwrite_q <= (state_d == S_MEM) && is_sw_d;
            regwrite_q <= (state_d == S_WB) && (is_r_d || is_i_d || is_lw_d);
            loadpc_q   <= (state_d == S_WB);
            illegal_q  <= (state_d == S_ID) && dec_illegal;
            if (state_q == S_EX)
                br_taken_q <= is_beq_d && Zero;
            else if (state_q == S_WB)
                br_taken_q <= 1'b0;
        end
    end

    assign ALUSrc        = alusrc_q;
    assign ALUCtrl       = aluctrl_q;
    assign MemRead       = memread_q;
    assign MemWrite      = memwrite_q;
    assign MemToReg      = memtoreg_q;
    assign RegWrite      = regwrite_q;
    assign loadPC        = loadpc_q;
    assign PCSrc         = br_taken_q;
    assign illegal_instr = illegal_q;
    assign dbg_state_o   = state_q;

endmodule
